uart_rx_os: RTL and testbench

Parametrised oversampling UART receiver, the successor to the fixed-format receiver in the FULL_UART set. It has these capabilities the fixed receiver lacks:
- programmable data width, parity mode and stop-bit count;
- a built-in oversample tick divider;
- input synchroniser and false-start rejection;
- parity, framing and overrun detection;
- valid/ready output handshake.

It sits between the serial pin and the consumer logic, replacing the baud_generator inrx tick path for the receive direction.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_os_tick.sv | 37 +++
 rtl/uart_rx_os.sv | 232 +++++++++++++++++++++++
 tb/tb_uart_rx_os.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the oversampling UART receiver: parity mode
// encodings, receive FSM state codes and a parity helper.
package uart_pkg;

  // parity_mode encodings (2'b11 is reserved and behaves as none)
  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  // Receive FSM state codes
  typedef logic [2:0] state_t;
  localparam state_t IDLE   = 3'd0;
  localparam state_t START  = 3'd1;
  localparam state_t DATA   = 3'd2;
  localparam state_t PARITY = 3'd3;
  localparam state_t STOP1  = 3'd4;
  localparam state_t STOP2  = 3'd5;

  // XOR reduction over a zero-extended data word (up to 9 data bits)
  function automatic logic calc_parity(input logic [8:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/uart_os_tick.sv
// Oversample tick divider: free-running counter 0..baud_div producing a
// one-cycle tick at each wrap. The divisor is captured at the wrap so a
// change mid-count can never strand the counter above its terminal value.
module uart_os_tick #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DIV_WIDTH-1:0] baud_div,
  output logic                 tick
);

  logic [DIV_WIDTH-1:0] cnt_r;
  logic [DIV_WIDTH-1:0] div_r;
  logic                 tick_r;
  logic                 wrap_s;

  assign wrap_s = (cnt_r == div_r);
  assign tick   = tick_r;

  // Count up to the captured divisor, wrap, reload divisor and pulse tick
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_r  <= {DIV_WIDTH{1'b0}};
      div_r  <= {DIV_WIDTH{1'b0}};
      tick_r <= 1'b0;
    end else if (wrap_s) begin
      cnt_r  <= {DIV_WIDTH{1'b0}};
      div_r  <= baud_div;
      tick_r <= 1'b1;
    end else begin
      cnt_r  <= cnt_r + {{(DIV_WIDTH-1){1'b0}}, 1'b1};
      tick_r <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver with programmable width/parity/stop bits,
// input synchroniser, false-start rejection, error flags and a
// valid/ready output register with sticky overrun.
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int DATA_BITS   = 8,
  parameter int OS_RATE     = 16,
  parameter int DIV_WIDTH   = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DIV_WIDTH-1:0] baud_div,
  input  logic [1:0]           parity_mode,
  input  logic                 two_stop,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int OS_W  = $clog2(OS_RATE);
  localparam int BIT_W = $clog2(DATA_BITS);
  localparam logic [OS_W-1:0]  OS_HALF  = OS_W'(OS_RATE/2 - 1);
  localparam logic [OS_W-1:0]  OS_LAST  = OS_W'(OS_RATE - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   rx_s;
  logic                   prev_r;
  logic                   tick_s;

  state_t                 state_r, state_nx;
  logic [OS_W-1:0]        os_cnt_r, os_nx;
  logic [BIT_W-1:0]       bit_cnt_r, bit_nx;
  logic [DATA_BITS-1:0]   shift_r, shift_nx;
  logic                   par_err_r, par_nx;
  logic                   frm_err_r, frm_nx;
  logic                   complete_s;
  logic                   half_pt_s;
  logic                   bit_pt_s;
  logic                   accept_s;

  logic [DATA_BITS-1:0]   rx_data_r;
  logic                   rx_valid_r;
  logic                   parity_err_r;
  logic                   frame_err_r;
  logic                   overrun_r;
  logic                   busy_r;

  assign rx_s       = sync_r[SYNC_STAGES-1];
  assign half_pt_s  = tick_s && (os_cnt_r == OS_HALF);
  assign bit_pt_s   = tick_s && (os_cnt_r == OS_LAST);
  assign accept_s   = rx_valid_r && rx_ready;

  assign rx_data    = rx_data_r;
  assign rx_valid   = rx_valid_r;
  assign parity_err = parity_err_r;
  assign frame_err  = frame_err_r;
  assign overrun    = overrun_r;
  assign busy       = busy_r;

  uart_os_tick #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_tick (
    .clk      (clk),
    .reset    (reset),
    .baud_div (baud_div),
    .tick     (tick_s)
  );

  // Synchronise the async line (idle high) and keep the previous sample
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_r <= {SYNC_STAGES{1'b1}};
      prev_r <= 1'b1;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], rx_in};
      prev_r <= rx_s;
    end
  end

  // Next-state logic: frame sequencing, sampling and error accumulation
  always_comb begin
    state_nx   = state_r;
    bit_nx     = bit_cnt_r;
    shift_nx   = shift_r;
    par_nx     = par_err_r;
    frm_nx     = frm_err_r;
    complete_s = 1'b0;
    if ((state_r != IDLE) && tick_s) begin
      os_nx = os_cnt_r + {{(OS_W-1){1'b0}}, 1'b1};
    end else begin
      os_nx = os_cnt_r;
    end

    case (state_r)
      IDLE: begin
        // only a genuine 1->0 transition starts a frame
        if (prev_r && !rx_s) begin
          state_nx = START;
          os_nx    = {OS_W{1'b0}};
          par_nx   = 1'b0;
          frm_nx   = 1'b0;
        end else begin
          state_nx = IDLE;
        end
      end
      START: begin
        if (half_pt_s) begin
          os_nx  = {OS_W{1'b0}};
          bit_nx = {BIT_W{1'b0}};
          if (rx_s) begin
            state_nx = IDLE;
          end else begin
            state_nx = DATA;
          end
        end else begin
          state_nx = START;
        end
      end
      DATA: begin
        if (bit_pt_s) begin
          os_nx    = {OS_W{1'b0}};
          shift_nx = {rx_s, shift_r[DATA_BITS-1:1]};
          if (bit_cnt_r == BIT_LAST) begin
            if ((parity_mode == PAR_EVEN) || (parity_mode == PAR_ODD)) begin
              state_nx = PARITY;
            end else begin
              state_nx = STOP1;
            end
          end else begin
            bit_nx = bit_cnt_r + {{(BIT_W-1){1'b0}}, 1'b1};
          end
        end else begin
          state_nx = DATA;
        end
      end
      PARITY: begin
        if (bit_pt_s) begin
          os_nx    = {OS_W{1'b0}};
          par_nx   = calc_parity(9'(shift_r)) ^ rx_s ^ (parity_mode == PAR_ODD);
          state_nx = STOP1;
        end else begin
          state_nx = PARITY;
        end
      end
      STOP1: begin
        if (bit_pt_s) begin
          os_nx  = {OS_W{1'b0}};
          frm_nx = frm_err_r | ~rx_s;
          if (two_stop) begin
            state_nx = STOP2;
          end else begin
            state_nx   = IDLE;
            complete_s = 1'b1;
          end
        end else begin
          state_nx = STOP1;
        end
      end
      STOP2: begin
        if (bit_pt_s) begin
          os_nx      = {OS_W{1'b0}};
          frm_nx     = frm_err_r | ~rx_s;
          state_nx   = IDLE;
          complete_s = 1'b1;
        end else begin
          state_nx = STOP2;
        end
      end
      default: begin
        state_nx = IDLE;
        os_nx    = {OS_W{1'b0}};
      end
    endcase
  end

  // FSM and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= IDLE;
      os_cnt_r  <= {OS_W{1'b0}};
      bit_cnt_r <= {BIT_W{1'b0}};
      shift_r   <= {DATA_BITS{1'b0}};
      par_err_r <= 1'b0;
      frm_err_r <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_nx;
      os_cnt_r  <= os_nx;
      bit_cnt_r <= bit_nx;
      shift_r   <= shift_nx;
      par_err_r <= par_nx;
      frm_err_r <= frm_nx;
      busy_r    <= (state_nx != IDLE);
    end
  end

  // Output word register with valid/ready handshake and sticky overrun
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_data_r    <= {DATA_BITS{1'b0}};
      rx_valid_r   <= 1'b0;
      parity_err_r <= 1'b0;
      frame_err_r  <= 1'b0;
      overrun_r    <= 1'b0;
    end else if (complete_s) begin
      if (rx_valid_r && !rx_ready) begin
        // pending word wins; the new one is dropped
        overrun_r <= 1'b1;
      end else begin
        rx_data_r    <= shift_r;
        parity_err_r <= par_err_r;
        frame_err_r  <= frm_nx;
        rx_valid_r   <= 1'b1;
        overrun_r    <= accept_s ? 1'b0 : overrun_r;
      end
    end else if (accept_s) begin
      rx_valid_r <= 1'b0;
      overrun_r  <= 1'b0;
    end else begin
      rx_valid_r <= rx_valid_r;
    end
  end

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench for uart_rx_os: frame formats, parity, framing, break,
// glitch rejection, overrun and mid-frame reset.
module tb_uart_rx_os;

  localparam int BAUD_DIV = 7;
  localparam int TICK_CLK = BAUD_DIV + 1;
  localparam int BIT_CLK  = 16 * TICK_CLK;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] baud_div;
  logic [1:0]  parity_mode;
  logic        two_stop;
  logic        rx_in;
  logic        rx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        parity_err;
  logic        frame_err;
  logic        overrun;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;
  int valid_cycles = 0;
  int vc0;

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } word_t;
  word_t acc_q[$];

  always #5 clk = ~clk;

  uart_rx_os #(
    .DATA_BITS   (8),
    .OS_RATE     (16),
    .DIV_WIDTH   (16),
    .SYNC_STAGES (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .baud_div    (baud_div),
    .parity_mode (parity_mode),
    .two_stop    (two_stop),
    .rx_in       (rx_in),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .parity_err  (parity_err),
    .frame_err   (frame_err),
    .overrun     (overrun),
    .busy        (busy)
  );

  // Record valid cycles and every accepted word
  always @(negedge clk) begin
    if (rx_valid) valid_cycles <= valid_cycles + 1;
    if (rx_valid && rx_ready) acc_q.push_back('{rx_data, parity_err, frame_err});
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      rx_in = bits[i];
      wait_clk(BIT_CLK);
    end
    rx_in = 1'b1;
  endtask

  task automatic check_word(input string tag, input logic [7:0] d, input logic pe, input logic fe);
    word_t w;
    check_val({tag, "_count"}, 32'(acc_q.size()), 32'd1);
    if (acc_q.size() > 0) begin
      w = acc_q.pop_front();
      check_val({tag, "_data"}, 32'(w.d), 32'(d));
      check_val({tag, "_perr"}, 32'(w.pe), 32'(pe));
      check_val({tag, "_ferr"}, 32'(w.fe), 32'(fe));
    end
    acc_q.delete();
  endtask

  initial begin
    baud_div    = 16'(BAUD_DIV);
    parity_mode = 2'b00;
    two_stop    = 1'b0;
    rx_in       = 1'b1;
    rx_ready    = 1'b1;
    reset       = 1'b0;
    wait_clk(3);
    check_val("rst_data",    32'(rx_data),    32'd0);
    check_val("rst_valid",   32'(rx_valid),   32'd0);
    check_val("rst_perr",    32'(parity_err), 32'd0);
    check_val("rst_ferr",    32'(frame_err),  32'd0);
    check_val("rst_overrun", 32'(overrun),    32'd0);
    check_val("rst_busy",    32'(busy),       32'd0);
    reset = 1'b1;
    wait_clk(BIT_CLK);

    // 8N1 0xA5
    vc0 = valid_cycles;
    send_bits({6'b0, 1'b1, 8'hA5, 1'b0}, 10);
    wait_clk(BIT_CLK);
    check_word("t1", 8'hA5, 1'b0, 1'b0);
    check_val("t1_valid_len", 32'(valid_cycles - vc0), 32'd1);
    check_val("t1_busy", 32'(busy), 32'd0);

    // 0x3C has four ones: parity bit 1 is wrong for even, right for odd
    parity_mode = 2'b01;
    send_bits({5'b0, 1'b1, 1'b1, 8'h3C, 1'b0}, 11);
    wait_clk(BIT_CLK);
    check_word("t2_even", 8'h3C, 1'b1, 1'b0);
    parity_mode = 2'b10;
    send_bits({5'b0, 1'b1, 1'b1, 8'h3C, 1'b0}, 11);
    wait_clk(BIT_CLK);
    check_word("t2_odd", 8'h3C, 1'b0, 1'b0);

    // 8N2 0x81 with second stop bit 0, then a break
    parity_mode = 2'b00;
    two_stop    = 1'b1;
    send_bits({4'b0, 1'b0, 1'b1, 8'h81, 1'b0}, 12);
    wait_clk(BIT_CLK);
    check_word("t3_stop2", 8'h81, 1'b0, 1'b1);
    wait_clk(BIT_CLK);
    rx_in = 1'b0;
    wait_clk(20 * BIT_CLK);
    check_word("t3_break", 8'h00, 1'b0, 1'b1);
    rx_in = 1'b1;
    wait_clk(4 * BIT_CLK);
    check_val("t3_no_more", 32'(acc_q.size()), 32'd0);

    // short glitch must be rejected as a false start
    two_stop = 1'b0;
    rx_in = 1'b0;
    wait_clk(2 * TICK_CLK);
    check_val("t4_busy_hi", 32'(busy), 32'd1);
    wait_clk(2 * TICK_CLK);
    rx_in = 1'b1;
    wait_clk(8 * TICK_CLK);
    check_val("t4_busy_lo", 32'(busy), 32'd0);
    wait_clk(BIT_CLK);
    check_val("t4_no_word", 32'(acc_q.size()), 32'd0);
    check_val("t4_valid", 32'(rx_valid), 32'd0);

    // overrun: second frame dropped while first is pending
    rx_ready = 1'b0;
    send_bits({6'b0, 1'b1, 8'h11, 1'b0}, 10);
    send_bits({6'b0, 1'b1, 8'h22, 1'b0}, 10);
    wait_clk(BIT_CLK);
    check_val("t5_valid", 32'(rx_valid), 32'd1);
    check_val("t5_data",  32'(rx_data),  32'h11);
    check_val("t5_ovr",   32'(overrun),  32'd1);
    rx_ready = 1'b1;
    wait_clk(1);
    rx_ready = 1'b0;
    wait_clk(2);
    check_val("t5_valid_clr", 32'(rx_valid), 32'd0);
    check_val("t5_ovr_clr",   32'(overrun),  32'd0);
    check_word("t5_acc", 8'h11, 1'b0, 1'b0);

    // reset during data bit 4 of 0x5A, then a clean 0x5A
    rx_ready = 1'b1;
    send_bits({6'b0, 1'b1, 8'h5A, 1'b0}, 5);
    rx_in = 1'b1;
    wait_clk(BIT_CLK / 2);
    check_val("t6_busy_mid", 32'(busy), 32'd1);
    reset = 1'b0;
    wait_clk(2);
    check_val("t6_rst_data",  32'(rx_data),  32'd0);
    check_val("t6_rst_valid", 32'(rx_valid), 32'd0);
    check_val("t6_rst_busy",  32'(busy),     32'd0);
    check_val("t6_rst_flags", 32'({parity_err, frame_err, overrun}), 32'd0);
    wait_clk(1);
    reset = 1'b1;
    wait_clk(12 * BIT_CLK);
    check_val("t6_no_partial", 32'(acc_q.size()), 32'd0);
    send_bits({6'b0, 1'b1, 8'h5A, 1'b0}, 10);
    wait_clk(BIT_CLK);
    check_word("t6_after", 8'h5A, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
